// File: rtl/floo_axis_noc_bridge_mc.sv
// floo_axis_noc_bridge_mc
//
// Multi-channel bridge between NumChannels NoC flit channels and one
// AXI-Stream link pair, flow-controlled by per-channel credits.
//
// TX: channels that have a flit and a credit are arbitrated round-robin.
// The winner is loaded into a single-entry output register and sent as one
// AXIS beat tagged with its channel index.
// RX: incoming beats are steered into per-channel FIFOs that drain to the
// NoC. Each FIFO pop frees one remote credit. Freed credits ride back on
// outgoing beats, or on credit-only beats when no flit is waiting.
//
// Beat layout, LSB first:
//   [0] flit_vld | [ChIdW:1] flit_ch | [FlitWidth+ChIdW:ChIdW+1] data |
//   cred_vld | top ChIdW bits cred_ch
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   flit_in_valid_i/ready_o/data_i       NoC -> AXIS flits, per channel
//   flit_out_valid_o/ready_i/data_o      AXIS -> NoC flits, per channel
//   axis_out_tvalid_o/tready_i/tdata_o   outgoing beats
//   axis_in_tvalid_i/tready_o/tdata_i    incoming beats
//   err_o                                sticky protocol-error flag
//
// Build option: define FLOO_AXIS_BRIDGE_ERR_EN to enable err_o. It then
// flags full-FIFO drops, credit saturation and out-of-range channel
// indices. Without it err_o is tied low. Drop and saturate behaviour is
// the same in both builds.
module floo_axis_noc_bridge_mc #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned FlitWidth   = 64,
    parameter int unsigned BufDepth    = 4,
    localparam int unsigned ChIdW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int unsigned CntW  = $clog2(BufDepth + 1),
    localparam int unsigned BeatW = FlitWidth + 2 * ChIdW + 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumChannels-1:0]           flit_in_valid_i,
    output logic [NumChannels-1:0]           flit_in_ready_o,
    input  logic [NumChannels*FlitWidth-1:0] flit_in_data_i,
    output logic [NumChannels-1:0]           flit_out_valid_o,
    input  logic [NumChannels-1:0]           flit_out_ready_i,
    output logic [NumChannels*FlitWidth-1:0] flit_out_data_o,
    output logic                             axis_out_tvalid_o,
    input  logic                             axis_out_tready_i,
    output logic [BeatW-1:0]                 axis_out_tdata_o,
    input  logic                             axis_in_tvalid_i,
    output logic                             axis_in_tready_o,
    input  logic [BeatW-1:0]                 axis_in_tdata_i,
    output logic                             err_o
);

    localparam int unsigned PtrW       = $clog2(BufDepth);
    localparam int unsigned DataLsb    = ChIdW + 1;
    localparam int unsigned CredVldBit = FlitWidth + ChIdW + 1;
    localparam int unsigned CredChLsb  = FlitWidth + ChIdW + 2;
    localparam logic [CntW-1:0]  DepthCnt = CntW'(BufDepth);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(BufDepth - 1);
    localparam logic [ChIdW:0]   NumChW   = (ChIdW + 1)'(NumChannels);
    localparam logic [ChIdW-1:0] LastCh   = ChIdW'(NumChannels - 1);

    // RX side
    logic                   rx_rdy_q;
    logic                   rx_acc;
    logic                   in_fv;
    logic                   in_cv;
    logic                   fch_ok;
    logic                   cch_ok;
    logic [ChIdW-1:0]       in_fch;
    logic [ChIdW-1:0]       in_cch;
    logic [FlitWidth-1:0]   in_data;
    logic [NumChannels-1:0] push;
    logic [NumChannels-1:0] pop;
    logic [NumChannels-1:0] cred_inc;

    logic [FlitWidth-1:0]   mem_q      [NumChannels][BufDepth];
    logic [PtrW-1:0]        wptr_q     [NumChannels];
    logic [PtrW-1:0]        rptr_q     [NumChannels];
    logic [CntW-1:0]        fifo_cnt_q [NumChannels];

    // TX side
    logic [CntW-1:0]        tx_cred_q   [NumChannels];
    logic [CntW-1:0]        pend_cred_q [NumChannels];
    logic [NumChannels-1:0] elig;
    logic [NumChannels-1:0] tx_dec;
    logic [NumChannels-1:0] pend_dec;
    logic [ChIdW-1:0]       rr_ptr_q;
    logic [ChIdW-1:0]       rr_nxt;
    logic [ChIdW-1:0]       grant;
    logic [ChIdW-1:0]       pend_ch;
    logic [31:0]            arb_idx;
    logic                   any_elig;
    logic                   any_pend;
    logic                   load_en;
    logic                   load_flit;
    logic                   load_cred;
    logic                   tx_vld_q;
    logic [BeatW-1:0]       beat_q;
    logic [BeatW-1:0]       beat_d;

    // ------------------------------------------------------------------
    // RX beat decode and FIFO control
    // ------------------------------------------------------------------
    assign axis_in_tready_o = rx_rdy_q;
    assign rx_acc  = axis_in_tvalid_i & rx_rdy_q;
    assign in_fv   = axis_in_tdata_i[0];
    assign in_fch  = axis_in_tdata_i[1 +: ChIdW];
    assign in_data = axis_in_tdata_i[DataLsb +: FlitWidth];
    assign in_cv   = axis_in_tdata_i[CredVldBit];
    assign in_cch  = axis_in_tdata_i[CredChLsb +: ChIdW];
    assign fch_ok  = ({1'b0, in_fch} < NumChW);
    assign cch_ok  = ({1'b0, in_cch} < NumChW);

    always_comb begin
        pop      = '0;
        push     = '0;
        cred_inc = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            pop[c]      = (fifo_cnt_q[c] != '0) && flit_out_ready_i[c];
            // A full FIFO still takes a flit when it is popped in the same cycle.
            push[c]     = rx_acc && in_fv && fch_ok && (in_fch == ChIdW'(c)) &&
                          ((fifo_cnt_q[c] != DepthCnt) || pop[c]);
            cred_inc[c] = rx_acc && in_cv && cch_ok && (in_cch == ChIdW'(c));
        end
    end

    always_comb begin
        flit_out_valid_o = '0;
        flit_out_data_o  = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            flit_out_valid_o[c] = (fifo_cnt_q[c] != '0);
            // Gate with valid so an empty FIFO drives zero.
            if (fifo_cnt_q[c] != '0) begin
                flit_out_data_o[c*FlitWidth +: FlitWidth] = mem_q[c][rptr_q[c]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_rdy_q <= 1'b0;
            for (int unsigned c = 0; c < NumChannels; c++) begin
                wptr_q[c]     <= '0;
                rptr_q[c]     <= '0;
                fifo_cnt_q[c] <= '0;
            end
        end else begin
            rx_rdy_q <= 1'b1;
            for (int unsigned c = 0; c < NumChannels; c++) begin
                if (push[c]) begin
                    wptr_q[c] <= (wptr_q[c] == PtrLast) ? '0 : wptr_q[c] + PtrW'(1);
                end
                if (pop[c]) begin
                    rptr_q[c] <= (rptr_q[c] == PtrLast) ? '0 : rptr_q[c] + PtrW'(1);
                end
                if (push[c] && !pop[c]) begin
                    fifo_cnt_q[c] <= fifo_cnt_q[c] + CntW'(1);
                end else if (pop[c] && !push[c]) begin
                    fifo_cnt_q[c] <= fifo_cnt_q[c] - CntW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // TX arbitration, credit piggyback and output register
    // ------------------------------------------------------------------
    always_comb begin
        elig = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            elig[c] = flit_in_valid_i[c] && (tx_cred_q[c] != '0);
        end
    end

    // Round-robin: scan from the pointer and take the first eligible channel.
    always_comb begin
        any_elig = 1'b0;
        grant    = '0;
        arb_idx  = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            arb_idx = 32'(rr_ptr_q) + i;
            if (arb_idx >= NumChannels) begin
                arb_idx = arb_idx - NumChannels;
            end
            if (!any_elig && elig[arb_idx[ChIdW-1:0]]) begin
                any_elig = 1'b1;
                grant    = arb_idx[ChIdW-1:0];
            end
        end
        rr_nxt = (grant == LastCh) ? '0 : grant + ChIdW'(1);
    end

    // The lowest-numbered channel with pending credit is returned first.
    always_comb begin
        any_pend = 1'b0;
        pend_ch  = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (!any_pend && (pend_cred_q[c] != '0)) begin
                any_pend = 1'b1;
                pend_ch  = ChIdW'(c);
            end
        end
    end

    assign load_en   = !tx_vld_q || axis_out_tready_i;
    assign load_flit = load_en && any_elig;
    assign load_cred = load_en && any_pend;

    always_comb begin
        flit_in_ready_o = '0;
        tx_dec          = '0;
        pend_dec        = '0;
        beat_d          = '0;
        if (load_flit) begin
            flit_in_ready_o[grant]       = 1'b1;
            tx_dec[grant]                = 1'b1;
            beat_d[0]                    = 1'b1;
            beat_d[1 +: ChIdW]           = grant;
            beat_d[DataLsb +: FlitWidth] = flit_in_data_i[32'(grant)*FlitWidth +: FlitWidth];
        end
        if (load_cred) begin
            pend_dec[pend_ch]           = 1'b1;
            beat_d[CredVldBit]          = 1'b1;
            beat_d[CredChLsb +: ChIdW]  = pend_ch;
        end
    end

    assign axis_out_tvalid_o = tx_vld_q;
    assign axis_out_tdata_o  = beat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_vld_q <= 1'b0;
            beat_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            // Register only changes when empty or draining, so a stalled beat holds.
            if (load_en) begin
                tx_vld_q <= load_flit || load_cred;
            end
            if (load_flit || load_cred) begin
                beat_q <= beat_d;
            end
            if (load_flit) begin
                rr_ptr_q <= rr_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned c = 0; c < NumChannels; c++) begin
                tx_cred_q[c]   <= DepthCnt;
                pend_cred_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NumChannels; c++) begin
                // A simultaneous spend and return cancel out.
                if (tx_dec[c] && !cred_inc[c]) begin
                    tx_cred_q[c] <= tx_cred_q[c] - CntW'(1);
                end else if (cred_inc[c] && !tx_dec[c] && (tx_cred_q[c] != DepthCnt)) begin
                    tx_cred_q[c] <= tx_cred_q[c] + CntW'(1);
                end
                // Saturate rather than wrap if the remote end ignores its credits.
                if (pop[c] && !pend_dec[c] && (pend_cred_q[c] != '1)) begin
                    pend_cred_q[c] <= pend_cred_q[c] + CntW'(1);
                end else if (pend_dec[c] && !pop[c]) begin
                    pend_cred_q[c] <= pend_cred_q[c] - CntW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional sticky error detection
    // ------------------------------------------------------------------
`ifdef FLOO_AXIS_BRIDGE_ERR_EN
    logic                   err_q;
    logic                   err_set;
    logic [NumChannels-1:0] full_drop;
    logic [NumChannels-1:0] cred_sat;

    always_comb begin
        full_drop = '0;
        cred_sat  = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            full_drop[c] = rx_acc && in_fv && fch_ok && (in_fch == ChIdW'(c)) &&
                           (fifo_cnt_q[c] == DepthCnt) && !pop[c];
            cred_sat[c]  = cred_inc[c] && !tx_dec[c] && (tx_cred_q[c] == DepthCnt);
        end
        err_set = (|full_drop) || (|cred_sat) ||
                  (rx_acc && ((in_fv && !fch_ok) || (in_cv && !cch_ok)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_axis_noc_bridge_mc.sv
// Directed testbench for floo_axis_noc_bridge_mc (NumChannels=2,
// FlitWidth=64, BufDepth=4). Expected TX beats and RX flits are queued when
// stimulus is applied and popped by monitors when the DUT hands them over.
module tb_floo_axis_noc_bridge_mc;

    localparam int unsigned NC  = 2;
    localparam int unsigned FW  = 64;
    localparam int unsigned BD  = 4;
    localparam int unsigned CHW = 1;
    localparam int unsigned BW  = FW + 2 * CHW + 2;

`ifdef FLOO_AXIS_BRIDGE_ERR_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    logic                clk_i;
    logic                rst_ni;
    logic [NC-1:0]       flit_in_valid_i;
    logic [NC-1:0]       flit_in_ready_o;
    logic [NC*FW-1:0]    flit_in_data_i;
    logic [NC-1:0]       flit_out_valid_o;
    logic [NC-1:0]       flit_out_ready_i;
    logic [NC*FW-1:0]    flit_out_data_o;
    logic                axis_out_tvalid_o;
    logic                axis_out_tready_i;
    logic [BW-1:0]       axis_out_tdata_o;
    logic                axis_in_tvalid_i;
    logic                axis_in_tready_o;
    logic [BW-1:0]       axis_in_tdata_i;
    logic                err_o;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0]     tx_q[$];
    logic [CHW+FW-1:0] rx_q[$];
    logic [BW-1:0]     tx_e;
    logic [CHW+FW-1:0] rx_e;
    logic [FW-1:0]     d0, d1;
    logic [FW-1:0]     abc [3];

    floo_axis_noc_bridge_mc #(
        .NumChannels(NC),
        .FlitWidth  (FW),
        .BufDepth   (BD)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flit_in_valid_i  (flit_in_valid_i),
        .flit_in_ready_o  (flit_in_ready_o),
        .flit_in_data_i   (flit_in_data_i),
        .flit_out_valid_o (flit_out_valid_o),
        .flit_out_ready_i (flit_out_ready_i),
        .flit_out_data_o  (flit_out_data_o),
        .axis_out_tvalid_o(axis_out_tvalid_o),
        .axis_out_tready_i(axis_out_tready_i),
        .axis_out_tdata_o (axis_out_tdata_o),
        .axis_in_tvalid_i (axis_in_tvalid_i),
        .axis_in_tready_o (axis_in_tready_o),
        .axis_in_tdata_i  (axis_in_tdata_i),
        .err_o            (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [BW-1:0] mk_beat(input logic fv, input logic [CHW-1:0] fch,
                                              input logic [FW-1:0] d, input logic cv,
                                              input logic [CHW-1:0] cch);
        logic [BW-1:0] b;
        b = '0;
        b[0]                 = fv;
        b[1 +: CHW]          = fch;
        b[CHW+1 +: FW]       = d;
        b[FW+CHW+1]          = cv;
        b[FW+CHW+2 +: CHW]   = cch;
        return b;
    endfunction

    // Fields that carry no meaning (channel/data of a credit-only beat,
    // cred_ch without cred_vld) are zeroed before comparison.
    function automatic logic [BW-1:0] beat_key(input logic [BW-1:0] b);
        logic [CHW-1:0] fch, cch;
        logic [FW-1:0]  d;
        fch = '0;
        cch = '0;
        d   = '0;
        if (b[0]) begin
            fch = b[1 +: CHW];
            d   = b[CHW+1 +: FW];
        end
        if (b[FW+CHW+1]) begin
            cch = b[FW+CHW+2 +: CHW];
        end
        return mk_beat(b[0], fch, d, b[FW+CHW+1], cch);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic in_beat(input logic fv, input logic [CHW-1:0] fch, input logic [FW-1:0] d,
                           input logic cv, input logic [CHW-1:0] cch);
        axis_in_tvalid_i = 1'b1;
        axis_in_tdata_i  = mk_beat(fv, fch, d, cv, cch);
        tick(1);
        axis_in_tvalid_i = 1'b0;
        axis_in_tdata_i  = '0;
    endtask

    task automatic do_reset();
        rst_ni            = 1'b0;
        flit_in_valid_i   = '0;
        flit_in_data_i    = '0;
        flit_out_ready_i  = '0;
        axis_out_tready_i = 1'b1;
        axis_in_tvalid_i  = 1'b0;
        axis_in_tdata_i   = '0;
        tick(2);
        chk("rst_tvalid", axis_out_tvalid_o, 1'b0);
        chk("rst_tdata", axis_out_tdata_o, '0);
        chk("rst_flit_out_valid", flit_out_valid_o, '0);
        chk("rst_flit_out_data", flit_out_data_o, '0);
        chk("rst_in_tready", axis_in_tready_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        rst_ni = 1'b1;
        tick(1);
        chk("in_tready_after_rst", axis_in_tready_o, 1'b1);
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rst_ni && axis_out_tvalid_o && axis_out_tready_i) begin
            chk("tx_beat_expected", tx_q.size() != 0, 1'b1);
            if (tx_q.size() != 0) begin
                tx_e = tx_q.pop_front();
                chk("tx_beat", beat_key(axis_out_tdata_o), tx_e);
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (rst_ni && flit_out_valid_o[c] && flit_out_ready_i[c]) begin
                chk("rx_flit_expected", rx_q.size() != 0, 1'b1);
                if (rx_q.size() != 0) begin
                    rx_e = rx_q.pop_front();
                    chk("rx_flit", {CHW'(c), flit_out_data_o[c*FW +: FW]}, rx_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        d0     = 64'hA0A0_0000_0000_0001;
        d1     = 64'hB1B1_0000_0000_0002;
        abc[0] = 64'hA;
        abc[1] = 64'hB;
        abc[2] = 64'hC;
        rst_ni = 1'b0;
        do_reset();

        // Credit return at full credit saturates; ch0 still sends only 4.
        in_beat(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("err_after_sat", err_o, ErrEn);
        for (int i = 0; i < 4; i++) tx_q.push_back(mk_beat(1'b1, 1'b0, d0, 1'b0, 1'b0));
        flit_in_data_i  = {d1, d0};
        flit_in_valid_i = 2'b01;
        tick(12);
        chk("a_ready_no_cred", flit_in_ready_o, 2'b00);
        chk("a_tvalid_idle", axis_out_tvalid_o, 1'b0);
        chk("a_tx_q_empty", tx_q.size(), 0);
        flit_in_valid_i = '0;

        // Round-robin alternation until both channels run out of credit.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) tx_q.push_back(mk_beat(1'b1, 1'b0, d0, 1'b0, 1'b0));
            else            tx_q.push_back(mk_beat(1'b1, 1'b1, d1, 1'b0, 1'b0));
        end
        flit_in_data_i  = {d1, d0};
        flit_in_valid_i = 2'b11;
        tick(14);
        chk("b_ready_no_cred", flit_in_ready_o, 2'b00);
        chk("b_tvalid_idle", axis_out_tvalid_o, 1'b0);
        chk("b_tx_q_empty", tx_q.size(), 0);
        flit_in_valid_i = '0;

        // Backpressure: the beat holds for 5 stalled cycles.
        do_reset();
        axis_out_tready_i = 1'b0;
        flit_in_data_i    = {d1, d0};
        flit_in_valid_i   = 2'b01;
        tx_q.push_back(mk_beat(1'b1, 1'b0, d0, 1'b0, 1'b0));
        tick(1);
        flit_in_valid_i = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("c_stall_tvalid", axis_out_tvalid_o, 1'b1);
            chk("c_stall_tdata", beat_key(axis_out_tdata_o), mk_beat(1'b1, 1'b0, d0, 1'b0, 1'b0));
        end
        tick(1);
        axis_out_tready_i = 1'b1;
        tick(1);
        chk("c_tvalid_after", axis_out_tvalid_o, 1'b0);
        tick(3);
        chk("c_tx_q_empty", tx_q.size(), 0);
        chk("c_tvalid_idle", axis_out_tvalid_o, 1'b0);

        // RX on ch1 with 1-cycle visibility, then three credit-only beats.
        do_reset();
        flit_out_ready_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            rx_q.push_back({1'b1, abc[i]});
            tx_q.push_back(mk_beat(1'b0, 1'b0, '0, 1'b1, 1'b1));
        end
        for (int i = 0; i < 3; i++) begin
            in_beat(1'b1, 1'b1, abc[i], 1'b0, 1'b0);
            chk("d_out_valid", flit_out_valid_o, 2'b10);
            chk("d_out_data", flit_out_data_o[FW +: FW], abc[i]);
        end
        tick(10);
        chk("d_rx_q_empty", rx_q.size(), 0);
        chk("d_tx_q_empty", tx_q.size(), 0);
        chk("d_out_valid_idle", flit_out_valid_o, 2'b00);
        chk("d_tvalid_idle", axis_out_tvalid_o, 1'b0);

        // Grant and credit return on ch0 in the same cycle at tx_cred=2.
        do_reset();
        for (int i = 0; i < 5; i++) tx_q.push_back(mk_beat(1'b1, 1'b0, d0, 1'b0, 1'b0));
        flit_in_data_i  = {d1, d0};
        flit_in_valid_i = 2'b01;
        tick(2);
        in_beat(1'b0, 1'b0, '0, 1'b1, 1'b0);
        tick(10);
        chk("e_ready_no_cred", flit_in_ready_o, 2'b00);
        chk("e_tx_q_empty", tx_q.size(), 0);
        chk("e_tvalid_idle", axis_out_tvalid_o, 1'b0);
        chk("e_err", err_o, 1'b0);
        flit_in_valid_i = '0;

        // Overflow: fifth flit into a full FIFO is dropped.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            rx_q.push_back({1'b0, FW'(i)});
            tx_q.push_back(mk_beat(1'b0, 1'b0, '0, 1'b1, 1'b0));
        end
        for (int i = 1; i <= 5; i++) in_beat(1'b1, 1'b0, FW'(i), 1'b0, 1'b0);
        chk("f_err_drop", err_o, ErrEn);
        chk("f_out_valid", flit_out_valid_o, 2'b01);
        chk("f_out_head", flit_out_data_o[FW-1:0], 64'd1);
        tick(3);
        chk("f_err_sticky", err_o, ErrEn);
        flit_out_ready_i = 2'b01;
        tick(12);
        chk("f_rx_q_empty", rx_q.size(), 0);
        chk("f_tx_q_empty", tx_q.size(), 0);
        chk("f_out_valid_idle", flit_out_valid_o, 2'b00);
        chk("f_err_still", err_o, ErrEn);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
